cpsr_flag_unit: RTL and testbench
=================================

Name: cpsr_flag_unit

Overview:
- Producer side of the condition-code interface: computes N/Z/C/V from ALU outputs, registers them and drives the 4-bit flag bus consumed by the condition tester.
- Sits between the ALU/shifter (execute stage) and the condition tester / instruction-issue logic.
- Two-stage update: a pending flag stage feeds the architectural flag register. The block also has a masked direct-write path (MSR-style) and a flush path.

Parameters:
- DATA_W, 32, width of the ALU result.
- CNT_W, 8, width of the saturating flag-update counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU outputs valid this cycle.
- s_bit  in  1  instruction requests flag update.
- op_class  in  2  00 logical, 01 arithmetic, 10 compare/test, 11 no-flag op.
- alu_result  in  DATA_W  ALU result.
- alu_cout  in  1  adder carry out.
- alu_ovf  in  1  adder signed overflow.
- shifter_cout  in  1  barrel-shifter carry out.
- msr_valid  in  1  direct flag write strobe.
- msr_mask  in  4  per-bit write enable, ordered {Z,C,N,V}.
- msr_data  in  4  direct write data, ordered {Z,C,N,V}.
- flush  in  1  squash the pending update.
- flags_out  out  4  flag bus to the condition tester, ordered {Z,C,N,V} (bit3=Z, bit2=C, bit1=N, bit0=V).
- flags_pending  out  1  pending stage holds an uncommitted update.
- update_count  out  CNT_W  saturating count of committed ALU flag updates.

Behaviour:
- Reset (async, reset_n=0): architectural flags=4'b0000, pending valid=0, pending flags=0, flags_out=4'b0000, flags_pending=0, update_count=0. Reset mid-update discards the pending update.
- Capture: when alu_valid & s_bit & op_class!=11 & !flush, the computed flags load into the pending stage at the rising edge. flags_pending=1 in the following cycle.
- Flag computation:
  - Logical: N=alu_result[DATA_W-1], Z=(alu_result==0), C=shifter_cout, V=current architectural V (unchanged).
  - Arithmetic/compare: N and Z as for logical, C=alu_cout, V=alu_ovf.
- Commit: a valid pending entry writes the architectural register on the next edge, so latency from capture edge to architectural update is 1 cycle. Back-to-back captures pipeline: the old entry commits while the new one loads, so no stall is needed.
- Each commit increments update_count, which saturates at all-ones.
- Flush: clears pending valid at the edge, so no commit occurs. A capture request in the same cycle as flush is dropped. An MSR write in the same cycle still applies.
- MSR write: when msr_valid=1, bits with msr_mask=1 take msr_data at the edge. It does not use the pending stage and does not count in update_count.
- MSR and commit in the same cycle: masked bits take msr_data; unmasked bits take pending values.
- MSR and capture in the same cycle: MSR writes architectural now. The captured value commits next cycle and overwrites all four bits.
- s_bit=0, alu_valid=0 or op_class=11: no state change.
- flags_out is registered architectural state unless the optional feature is enabled.

Optional Feature:
- Macro: CPSR_FLAG_BYPASS_EN.
- Defined: flags_out is combinational = next architectural value, i.e. the pending entry merged with any MSR write per the rules above. The condition tester then sees new flags the cycle the pending entry is valid, saving one cycle.
- Undefined: flags_out = architectural register only; consumers must wait for flags_pending=0.

Decomposition:
- Shared package holds:
  - op_class encodings (OPC_LOGIC, OPC_ARITH, OPC_CMP, OPC_NONE).
  - Flag bit indices (FLG_Z=3, FLG_C=2, FLG_N=1, FLG_V=0).
- One sub-module: cpsr_flag_calc, a combinational N/Z/C/V generator from alu_result/couts/op_class.

Test Plan:
- Reset mid-operation: capture arith then assert reset_n=0 before commit -> flags_out=0000, flags_pending=0, update_count=0 immediately.
- Arith zero result, no overflow: alu_result=0, alu_cout=1, alu_ovf=0, op_class=01, s_bit=1 -> one cycle later flags_pending=1; next cycle flags_out=1100, update_count=1.
- Logical negative result: alu_result=32'h8000_0000, shifter_cout=0, prior V=1 -> flags_out=0011 (V retained).
- Collision and flush:
  - msr_mask=1000, msr_data=0000 in the commit cycle of a 1100 update -> flags_out=0100.
  - flush during pending -> flags unchanged, count unchanged.
- Saturation and back-to-back: 300 consecutive valid captures with CNT_W=8 -> every update commits in order, update_count stops at 255.
- Bypass: with CPSR_FLAG_BYPASS_EN defined, the 1100 update appears on flags_out one cycle earlier than without the macro.

Source files
------------

// File: rtl/cpsr_flag_unit_pkg.sv
// Shared encodings for the condition-code producer: op_class values and
// bit positions of the {Z,C,N,V} flag bus.
package cpsr_flag_unit_pkg;

    typedef enum logic [1:0] {
        OPC_LOGIC = 2'b00,
        OPC_ARITH = 2'b01,
        OPC_CMP   = 2'b10,
        OPC_NONE  = 2'b11
    } opc_e;

    localparam int FLG_Z = 3;
    localparam int FLG_C = 2;
    localparam int FLG_N = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/cpsr_flag_unit_calc.sv
// Combinational N/Z/C/V generator from ALU/shifter outputs; logical ops keep
// the incoming V and take C from the shifter.
module cpsr_flag_calc
    import cpsr_flag_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]               op_class,
    input  logic signed [DATA_W-1:0] alu_result,
    input  logic                     alu_cout,
    input  logic                     alu_ovf,
    input  logic                     shifter_cout,
    input  logic                     cur_v,
    output logic [3:0]               flags
);

    always_comb begin
        flags        = '0;
        flags[FLG_N] = alu_result[DATA_W-1];
        flags[FLG_Z] = (alu_result == '0);
        if (op_class == OPC_LOGIC) begin
            flags[FLG_C] = shifter_cout;
            flags[FLG_V] = cur_v;
        end else begin
            flags[FLG_C] = alu_cout;
            flags[FLG_V] = alu_ovf;
        end
    end

endmodule

// File: rtl/cpsr_flag_unit.sv
// Condition-code producer: pending flag stage feeding the architectural
// flag register, with masked MSR writes and flush. Option: CPSR_FLAG_BYPASS_EN.
module cpsr_flag_unit
    import cpsr_flag_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alu_valid,
    input  logic              s_bit,
    input  logic [1:0]        op_class,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cout,
    input  logic              alu_ovf,
    input  logic              shifter_cout,
    input  logic              msr_valid,
    input  logic [3:0]        msr_mask,
    input  logic [3:0]        msr_data,
    input  logic              flush,
    output logic [3:0]        flags_out,
    output logic              flags_pending,
    output logic [CNT_W-1:0]  update_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic             vld_p0;
    logic [3:0]       flags_p0;
    logic [3:0]       flags_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic             capture;
    logic             commit;
    logic [3:0]       arch_nxt;
    logic [3:0]       calc_flags;

    always_comb begin
        capture  = alu_valid & s_bit & (op_class != OPC_NONE) & ~flush;
        commit   = vld_p0 & ~flush;
        arch_nxt = commit ? flags_p0 : flags_p1;
        if (msr_valid) begin
            arch_nxt = (arch_nxt & ~msr_mask) | (msr_data & msr_mask);
        end
    end

    // Logical ops retain V as it will stand once the older entry/MSR lands,
    // so back-to-back captures never resurrect a stale V.
    cpsr_flag_calc #(
        .DATA_W (DATA_W)
    ) u_calc (
        .op_class     (op_class),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .alu_ovf      (alu_ovf),
        .shifter_cout (shifter_cout),
        .cur_v        (arch_nxt[FLG_V]),
        .flags        (calc_flags)
    );

    // p0: pending stage -> p1: architectural flags and commit counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0   <= 1'b0;
            flags_p0 <= '0;
            flags_p1 <= '0;
            cnt_p1   <= '0;
        end else begin
            vld_p0   <= capture;
            if (capture) begin
                flags_p0 <= calc_flags;
            end
            flags_p1 <= arch_nxt;
            if (commit) begin
                cnt_p1 <= sat_inc(cnt_p1);
            end
        end
    end

`ifdef CPSR_FLAG_BYPASS_EN
    assign flags_out = arch_nxt;
`else
    assign flags_out = flags_p1;
`endif
    assign flags_pending = vld_p0;
    assign update_count  = cnt_p1;

endmodule

// File: tb/tb_cpsr_flag_unit.sv
// Scoreboard bench for cpsr_flag_unit: queue-based reference model, directed
// scenarios followed by randomized traffic.
module tb_cpsr_flag_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_valid, s_bit, alu_cout, alu_ovf, shifter_cout;
    logic        msr_valid, flush;
    logic [1:0]  op_class;
    logic [31:0] alu_result;
    logic [3:0]  msr_mask, msr_data;
    logic [3:0]  flags_out;
    logic        flags_pending;
    logic [7:0]  update_count;

    always #5 clk = ~clk;

    cpsr_flag_unit #(.DATA_W(32), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .alu_valid(alu_valid), .s_bit(s_bit),
        .op_class(op_class), .alu_result(alu_result), .alu_cout(alu_cout),
        .alu_ovf(alu_ovf), .shifter_cout(shifter_cout), .msr_valid(msr_valid),
        .msr_mask(msr_mask), .msr_data(msr_data), .flush(flush),
        .flags_out(flags_out), .flags_pending(flags_pending),
        .update_count(update_count)
    );

    typedef struct packed {
        logic [3:0] f;
        logic       p;
        logic [7:0] c;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] pq[$];     // uncommitted flag updates, oldest first
    logic [3:0] m_arch;
    int         m_cnt;
    int         n_cmp = 0;
    int         n_bad = 0;

`ifdef CPSR_FLAG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("flags_out", int'(flags_out), int'(e.f));
                chk("flags_pending", int'(flags_pending), int'(e.p));
                chk("update_count", int'(update_count), int'(e.c));
            end
        end
    end

    task automatic cycle(input logic av, input logic sb, input logic [1:0] opc,
                         input logic [31:0] res, input logic co, input logic ov,
                         input logic sc, input logic mv, input logic [3:0] mm,
                         input logic [3:0] md, input logic fl);
        logic [3:0] nxt;
        logic [3:0] nf;
        logic       cmt;
        exp_t       e;
        @(posedge clk);
        #1;
        alu_valid = av; s_bit = sb; op_class = opc; alu_result = res;
        alu_cout = co; alu_ovf = ov; shifter_cout = sc;
        msr_valid = mv; msr_mask = mm; msr_data = md; flush = fl;
        cmt = (pq.size() > 0) && !fl;
        nxt = cmt ? pq[0] : m_arch;
        for (int i = 0; i < 4; i++)
            if (mv && mm[i]) nxt[i] = md[i];
        e.f = BYPASS ? nxt : m_arch;
        e.p = (pq.size() > 0);
        e.c = 8'(m_cnt);
        sb_q.push_back(e);
        if (pq.size() > 0) void'(pq.pop_front());
        if (cmt && m_cnt < 255) m_cnt++;
        if (av && sb && opc != 2'b11 && !fl) begin
            nf[3] = (res == 32'd0);
            nf[1] = res[31];
            nf[2] = (opc == 2'b00) ? sc : co;
            nf[0] = (opc == 2'b00) ? nxt[0] : ov;
            pq.push_back(nf);
        end
        m_arch = nxt;
    endtask

    task automatic idle();
        cycle(0, 0, 2'b11, 32'd0, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    endtask

    task automatic arith(input logic [31:0] res, input logic co, input logic ov,
                         input logic fl);
        cycle(1, 1, 2'b01, res, co, ov, 0, 0, 4'h0, 4'h0, fl);
    endtask

    task automatic expect_now(input string name, input logic [3:0] f,
                              input logic p, input int c);
        @(negedge clk);
        #1;
        chk({name, ".flags"}, int'(flags_out), int'(f));
        chk({name, ".pending"}, int'(flags_pending), int'(p));
        chk({name, ".count"}, int'(update_count), c);
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #1;
        alu_valid = 0; s_bit = 0; msr_valid = 0; flush = 0;
        #1;
        reset_n = 1'b0;
        m_arch = 4'h0; m_cnt = 0; pq.delete();
        #1;
        chk("rst.flags", int'(flags_out), 0);
        chk("rst.pending", int'(flags_pending), 0);
        chk("rst.count", int'(update_count), 0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        alu_valid = 0; s_bit = 0; op_class = 2'b11; alu_result = '0;
        alu_cout = 0; alu_ovf = 0; shifter_cout = 0;
        msr_valid = 0; msr_mask = '0; msr_data = '0; flush = 0;
        m_arch = 4'h0; m_cnt = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        idle();
        expect_now("reset", 4'h0, 0, 0);

        // arithmetic zero result: Z=1 C=1 N=0 V=0
        arith(32'd0, 1, 0, 0);
        idle(); idle();
        expect_now("arith_zero", 4'b1100, 0, 1);

        // logical negative keeps prior V
        cycle(0, 0, 2'b11, 32'd0, 0, 0, 0, 1, 4'b0001, 4'b0001, 0);
        cycle(1, 1, 2'b00, 32'h8000_0000, 1, 0, 0, 0, 4'h0, 4'h0, 0);
        idle(); idle();
        expect_now("logic_neg", 4'b0011, 0, 2);

        // MSR clears Z in the commit cycle of a 1100 update
        arith(32'd0, 1, 0, 0);
        cycle(0, 0, 2'b11, 32'd0, 0, 0, 0, 1, 4'b1000, 4'b0000, 0);
        idle(); idle();
        expect_now("msr_collide", 4'b0100, 0, 3);

        // flush while pending squashes the commit
        arith(32'd1, 0, 1, 0);
        cycle(0, 0, 2'b11, 32'd0, 0, 0, 0, 0, 4'h0, 4'h0, 1);
        idle();
        expect_now("flush_pend", 4'b0100, 0, 3);

        // capture in a flush cycle is dropped
        arith(32'd0, 1, 1, 1);
        idle(); idle();
        expect_now("flush_cap", 4'b0100, 0, 3);

        arith(32'd0, 1, 0, 0);
        reset_mid();
        idle();

        // 300 back-to-back captures saturate the counter
        for (int i = 0; i < 300; i++) begin
            cycle(1, 1, 2'($urandom_range(0, 2)),
                  ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom,
                  1'($urandom), 1'($urandom), 1'($urandom), 0, 4'h0, 4'h0, 0);
        end
        idle(); idle();
        expect_now("saturate", m_arch, 0, 255);

        arith(32'd5, 0, 0, 0);
        reset_mid();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                  1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 4) == 0, 4'($urandom), 4'($urandom),
                  $urandom_range(0, 7) == 0);
        end
        idle(); idle(); idle();

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
